// File: rtl/dram_slot_arbiter_pkg.sv
// rtl/dram_slot_arbiter_pkg.sv - shared owner tags, bandwidth codes and slot helpers
package dram_slot_arbiter_pkg;

  // Who is waiting for read data at the end of the owner pipeline
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  // Winner of one DRAM slot
  typedef enum logic [1:0] {
    WIN_IDLE = 2'd0,
    WIN_VID  = 2'd1,
    WIN_REFR = 2'd2,
    WIN_CPU  = 2'd3
  } win_t;

  // Video bandwidth codes (slots per 16); any bw with bit 1 set means 8
  localparam logic [1:0] BW_2 = 2'b00;
  localparam logic [1:0] BW_4 = 2'b01;

  // True when the given slot number belongs to video at the given bandwidth
  function automatic logic is_video_slot(input logic [1:0] bw, input logic [3:0] slot);
    if (bw == BW_2)      return slot[2:0] == 3'b000;
    else if (bw == BW_4) return slot[1:0] == 2'b00;
    else                 return slot[0] == 1'b0;
  endfunction

endpackage

// File: rtl/dram_slot_arbiter_owner_pipe.sv
// rtl/dram_slot_arbiter_owner_pipe.sv - read-data owner tag shift register
module dram_slot_arbiter_owner_pipe
  import dram_slot_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_in,
  output logic   vid_strobe,
  output logic   cpu_strobe
);

  owner_t stage [DEPTH];

  // Shift the owner tags one stage per clock; reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign vid_strobe = (stage[DEPTH-1] == OWN_VID);
  assign cpu_strobe = (stage[DEPTH-1] == OWN_CPU);

endmodule

// File: rtl/dram_slot_arbiter.sv
// rtl/dram_slot_arbiter.sv - per-slot DRAM owner arbitration between video, CPU and refresh
module dram_slot_arbiter
  import dram_slot_arbiter_pkg::*;
#(
  parameter int RD_LAT      = 3,
  parameter int REFR_PERIOD = 78
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cend,
  input  logic        go,
  input  logic [1:0]  bw,
  input  logic [20:0] video_addr,
  output logic        video_next,
  output logic        video_strobe,
  output logic [15:0] video_data,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_bsel,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic [15:0] cpu_rdata,
  output logic        dram_req,
  output logic        dram_refr,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [1:0]  dram_bsel,
  output logic [15:0] dram_wdata,
  input  logic [15:0] dram_rdata
);

  localparam int RW = (REFR_PERIOD > 2) ? $clog2(REFR_PERIOD) : 1;
  localparam logic [RW-1:0] REFR_LAST = RW'(REFR_PERIOD - 1);

  logic [3:0]    slot;
  logic          go_q;
  logic [RW-1:0] refr_cnt;
  logic [1:0]    refr_pend;
  owner_t        grant_tag;

  logic       restart;
  logic [3:0] eff_slot;
  logic       vid_win;
  logic       refr_wrap;
  win_t       win;

  // A fresh fetch window restarts the slot pattern at slot 0
  assign restart   = go & ~go_q;
  assign eff_slot  = restart ? 4'd0 : slot;
  assign vid_win   = go & is_video_slot(bw, eff_slot);
  assign refr_wrap = (refr_cnt == REFR_LAST);

  // Slot owner by priority; video slots are never handed to anyone else
  always_comb begin
    win = WIN_IDLE;
    if (vid_win)                 win = WIN_VID;
    else if (refr_pend == 2'd3)  win = WIN_REFR;
    else if (cpu_req)            win = WIN_CPU;
    else if (refr_pend != 2'd0)  win = WIN_REFR;
  end

  // Slot counter, window edge tracking and refresh bookkeeping advance on cend only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= 4'd0;
      go_q      <= 1'b0;
      refr_cnt  <= '0;
      refr_pend <= 2'd0;
    end else if (cend) begin
      slot     <= eff_slot + 4'd1;
      go_q     <= go;
      refr_cnt <= refr_wrap ? '0 : refr_cnt + 1'b1;
      if (refr_wrap && win != WIN_REFR && refr_pend != 2'd3) refr_pend <= refr_pend + 2'd1;
      else if (!refr_wrap && win == WIN_REFR)                refr_pend <= refr_pend - 2'd1;
    end
  end

  // Grant outputs are one-clock pulses following the deciding cend edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_req   <= 1'b0;
      dram_refr  <= 1'b0;
      dram_rnw   <= 1'b0;
      dram_addr  <= '0;
      dram_bsel  <= '0;
      dram_wdata <= '0;
      video_next <= 1'b0;
      cpu_next   <= 1'b0;
      grant_tag  <= OWN_NONE;
    end else begin
      dram_req   <= 1'b0;
      dram_refr  <= 1'b0;
      dram_rnw   <= 1'b0;
      dram_addr  <= '0;
      dram_bsel  <= '0;
      dram_wdata <= '0;
      video_next <= 1'b0;
      cpu_next   <= 1'b0;
      grant_tag  <= OWN_NONE;
      if (cend) begin
        case (win)
          WIN_VID: begin
            dram_req   <= 1'b1;
            dram_rnw   <= 1'b1;
            dram_addr  <= video_addr;
            dram_bsel  <= 2'b11;
            video_next <= 1'b1;
            grant_tag  <= OWN_VID;
          end
          WIN_CPU: begin
            dram_req   <= 1'b1;
            dram_rnw   <= cpu_rnw;
            dram_addr  <= cpu_addr;
            dram_bsel  <= cpu_rnw ? 2'b11 : cpu_bsel;
            dram_wdata <= cpu_rnw ? 16'h0000 : cpu_wdata;
            cpu_next   <= 1'b1;
            grant_tag  <= cpu_rnw ? OWN_CPU : OWN_NONE;
          end
          WIN_REFR: dram_refr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // The registered grant tag plus RD_LAT stages lines the strobe up with read data
  dram_slot_arbiter_owner_pipe #(.DEPTH(RD_LAT)) u_owner_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .tag_in     (grant_tag),
    .vid_strobe (video_strobe),
    .cpu_strobe (cpu_strobe)
  );

  assign video_data = video_strobe ? dram_rdata : 16'h0000;
  assign cpu_rdata  = cpu_strobe   ? dram_rdata : 16'h0000;

endmodule

// File: tb/tb_dram_slot_arbiter.sv
// tb/tb_dram_slot_arbiter.sv - directed self-checking bench for dram_slot_arbiter
module tb_dram_slot_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cend;
  logic        go;
  logic [1:0]  bw;
  logic [20:0] video_addr;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [20:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_bsel;
  logic [15:0] dram_rdata;

  logic        video_next, video_strobe, cpu_next, cpu_strobe;
  logic [15:0] video_data, cpu_rdata, dram_wdata;
  logic        dram_req, dram_refr, dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;

  logic        r_video_next, r_video_strobe, r_cpu_next, r_cpu_strobe;
  logic [15:0] r_video_data, r_cpu_rdata, r_dram_wdata;
  logic        r_dram_req, r_dram_refr, r_dram_rnw;
  logic [20:0] r_dram_addr;
  logic [1:0]  r_dram_bsel;

  always #5 clk = ~clk;

  dram_slot_arbiter #(.RD_LAT(3), .REFR_PERIOD(78)) dut (
    .clk(clk), .rst_n(rst_n), .cend(cend), .go(go), .bw(bw), .video_addr(video_addr),
    .video_next(video_next), .video_strobe(video_strobe), .video_data(video_data),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bsel(cpu_bsel), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_rdata(cpu_rdata),
    .dram_req(dram_req), .dram_refr(dram_refr), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_bsel(dram_bsel), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata)
  );

  dram_slot_arbiter #(.RD_LAT(3), .REFR_PERIOD(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .cend(cend), .go(go), .bw(bw), .video_addr(video_addr),
    .video_next(r_video_next), .video_strobe(r_video_strobe), .video_data(r_video_data),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bsel(cpu_bsel), .cpu_next(r_cpu_next), .cpu_strobe(r_cpu_strobe), .cpu_rdata(r_cpu_rdata),
    .dram_req(r_dram_req), .dram_refr(r_dram_refr), .dram_rnw(r_dram_rnw), .dram_addr(r_dram_addr),
    .dram_bsel(r_dram_bsel), .dram_wdata(r_dram_wdata), .dram_rdata(dram_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Values captured by do_slot
  logic        go_want;
  logic        g_req, g_refr, g_rnw, g_vnext, g_cnext;
  logic [20:0] g_addr;
  logic [1:0]  g_bsel;
  logic [15:0] g_wdata;
  logic        r_g_req, r_g_refr, r_g_vnext, r_g_cnext;
  logic        s_vid, s_cpu, stray, hold;
  logic [15:0] s_vdata, s_cdata;

  task automatic do_reset();
    cend = 1'b0; go = 1'b0; go_want = 1'b0; cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One slot: cend pulse, capture grant cycle, then watch for the strobe 3 clocks later
  task automatic do_slot(input logic drop_go);
    @(negedge clk); cend = 1'b1; go = go_want;
    @(negedge clk); cend = 1'b0;
    g_req = dram_req; g_refr = dram_refr; g_rnw = dram_rnw; g_vnext = video_next;
    g_cnext = cpu_next; g_addr = dram_addr; g_bsel = dram_bsel; g_wdata = dram_wdata;
    r_g_req = r_dram_req; r_g_refr = r_dram_refr; r_g_vnext = r_video_next; r_g_cnext = r_cpu_next;
    if (drop_go) begin go = 1'b0; go_want = 1'b0; end
    stray = 1'b0; hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        s_vid = video_strobe; s_cpu = cpu_strobe; s_vdata = video_data; s_cdata = cpu_rdata;
      end else begin
        stray = stray | video_strobe | cpu_strobe;
      end
      if (k == 1) hold = video_next | cpu_next | dram_req | dram_refr;
    end
  endtask

  int vcount, ccount;

  initial begin
    rst_n = 1'b0; cend = 1'b0; go = 1'b1; go_want = 1'b0; bw = 2'b00;
    video_addr = 21'h0; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h0;
    cpu_wdata = 16'h0; cpu_bsel = 2'b00; dram_rdata = 16'h5555;

    // 1. reset held with cend toggling
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); cend = ~cend;
    end
    @(negedge clk); cend = 1'b0;
    check("rst_ctrl", {dram_req, dram_refr, video_next, cpu_next, video_strobe, cpu_strobe, dram_rnw}, 32'h0);
    check("rst_addr", dram_addr, 32'h0);
    check("rst_bsel_wdata", {dram_bsel, dram_wdata}, 32'h0);
    check("rst_data", {video_data, cpu_rdata}, 32'h0);
    go = 1'b0; cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_slot(1'b0);
    check("idle_after_rst", {g_req, g_refr, g_vnext, g_cnext}, 32'h0);
    do_slot(1'b0);
    check("idle_after_rst2", {g_req, g_refr, g_vnext, g_cnext}, 32'h0);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h12345;
    do_slot(1'b0);
    cpu_req = 1'b0;
    check("first_req", {g_req, g_cnext, g_rnw, g_bsel}, {27'h0, 5'b11111});
    check("first_addr", g_addr, 32'h12345);
    check("first_strobe", {s_cpu, s_vid, stray}, 32'b100);
    check("first_rdata", s_cdata, 32'h5555);

    // async reset between grant and strobe discards the strobe
    cpu_req = 1'b1;
    @(negedge clk); cend = 1'b1;
    @(negedge clk); cend = 1'b0; cpu_req = 1'b0;
    check("pre_rst_req", dram_req, 32'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); stray = stray | cpu_strobe | dram_req | cpu_next;
    end
    check("rst_drops_strobe", stray, 32'h0);

    // 2. bw=00, CPU reads held: video on slots 0 and 8, CPU elsewhere
    do_reset();
    bw = 2'b00; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h00200;
    video_addr = 21'h00300; dram_rdata = 16'hA5A5; go_want = 1'b1;
    vcount = 0; ccount = 0;
    for (int i = 0; i < 32; i++) begin
      do_slot(1'b0);
      vcount += int'(g_vnext); ccount += int'(g_cnext);
      check($sformatf("bw2_slot%0d_next", i), {g_vnext, g_cnext}, ((i % 8) == 0) ? 32'b10 : 32'b01);
      check($sformatf("bw2_slot%0d_strobe", i), {s_vid, s_cpu, stray}, ((i % 8) == 0) ? 32'b100 : 32'b010);
    end
    check("bw2_vid_total", vcount, 32'd4);
    check("bw2_cpu_total", ccount, 32'd28);
    cpu_req = 1'b0; go_want = 1'b0;

    // 3. bw=01 video read path
    do_reset();
    bw = 2'b01; video_addr = 21'h0A000; dram_rdata = 16'h1234; go_want = 1'b1;
    do_slot(1'b0);
    check("vid_req", {g_req, g_rnw, g_vnext, g_bsel}, 32'b11111);
    check("vid_addr", g_addr, 32'h0A000);
    check("vid_next_1clk", hold, 32'h0);
    check("vid_strobe", {s_vid, stray}, 32'b10);
    check("vid_data", s_vdata, 32'h1234);
    for (int i = 1; i < 5; i++) begin
      do_slot(1'b0);
      check($sformatf("bw4_slot%0d", i), {g_req, g_vnext}, (i == 4) ? 32'b11 : 32'b00);
    end
    go_want = 1'b0;

    // 4. CPU write
    do_reset();
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h01F00; cpu_wdata = 16'hBEEF; cpu_bsel = 2'b01;
    do_slot(1'b0);
    cpu_req = 1'b0;
    check("wr_ctrl", {g_req, g_rnw, g_cnext, g_refr}, 32'b1010);
    check("wr_bsel", g_bsel, 32'h1);
    check("wr_addr", g_addr, 32'h01F00);
    check("wr_wdata", g_wdata, 32'hBEEF);
    check("wr_no_strobe", {s_cpu, s_vid, stray}, 32'h0);
    do_slot(1'b0);
    check("wr_dropped_idle", {g_req, g_refr, g_cnext}, 32'h0);

    // 5. refresh priority with REFR_PERIOD=4
    do_reset();
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h00100;
    for (int k = 1; k <= 16; k++) begin
      do_slot(1'b0);
      check($sformatf("refr_cend%0d", k), {r_g_refr, r_g_cnext, r_g_req}, (k == 13) ? 32'b100 : 32'b011);
    end
    bw = 2'b10; go_want = 1'b1;
    do_slot(1'b0);
    check("refr_waits_video", {r_g_vnext, r_g_refr, r_g_cnext}, 32'b100);
    do_slot(1'b0);
    check("refr_after_video", {r_g_vnext, r_g_refr, r_g_cnext}, 32'b010);
    go_want = 1'b0; cpu_req = 1'b0;

    // 6. go dropped right after a video grant
    do_reset();
    bw = 2'b00; dram_rdata = 16'h7E57; go_want = 1'b1;
    do_slot(1'b1);
    check("drop_vid_next", g_vnext, 32'h1);
    check("drop_vid_strobe", {s_vid, s_vdata}, {15'h0, 1'b1, 16'h7E57});
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      do_slot(1'b0);
      vcount += int'(g_vnext) + int'(g_req);
    end
    check("drop_no_more_video", vcount, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
